// File: rtl/shep_fifo_stat.sv
// shep_fifo_stat -- single-clock synchronous FIFO with occupancy statistics.
//
// Stores all `depth` entries by carrying one extra pointer bit, so full and
// empty are told apart by the pointer MSB. Provides an exact occupancy count,
// almost-full / almost-empty thresholds, sticky overflow / underflow flags and
// a peak-occupancy high-water mark.
//
// Ports:
//   clk        clock, all state on rising edge
//   reset      synchronous active-high reset
//   wr_data    write word
//   push       write request (rejected while full)
//   rd_data    head-of-queue word (combinational; don't-care while empty)
//   pop        read request (rejected while empty)
//   clr_err    clears overflow / underflow, reloads peak with next occupancy
//   empty      occupancy == 0
//   full       occupancy == depth
//   afull      free entries <= afull_lvl
//   aempty     occupancy <= aempty_lvl
//   count      current occupancy, 0..depth
//   peak       maximum occupancy since reset or clr_err
//   overflow   sticky: a push was rejected
//   underflow  sticky: a pop was rejected
module shep_fifo_stat #(
   parameter int width      = 64,
   parameter int depth      = 256,
   parameter int dbit       = 8,
   parameter int afull_lvl  = 7,
   parameter int aempty_lvl = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [width-1:0] wr_data,
   input  logic             push,
   output logic [width-1:0] rd_data,
   input  logic             pop,
   input  logic             clr_err,
   output logic             empty,
   output logic             full,
   output logic             afull,
   output logic             aempty,
   output logic [dbit:0]    count,
   output logic [dbit:0]    peak,
   output logic             overflow,
   output logic             underflow
);

   localparam logic [dbit:0] DEPTH_C  = (dbit+1)'(depth);
   localparam logic [dbit:0] AFULL_C  = (dbit+1)'(depth - afull_lvl);
   localparam logic [dbit:0] AEMPTY_C = (dbit+1)'(aempty_lvl);

   logic [width-1:0] mem [depth];

   logic [dbit:0] wr_ptr_q, wr_ptr_d;
   logic [dbit:0] rd_ptr_q, rd_ptr_d;
   logic [dbit:0] peak_q, peak_d;
   logic [dbit:0] count_d;
   logic          overflow_q, overflow_d;
   logic          underflow_q, underflow_d;
   logic          push_ok, pop_ok;
   logic          ovf_ev, unf_ev;

   // Flags depend only on the registered pointers, never on this cycle's requests.
   assign count  = wr_ptr_q - rd_ptr_q;
   assign empty  = (count == '0);
   assign full   = (count == DEPTH_C);
   assign afull  = (count >= AFULL_C);
   assign aempty = (count <= AEMPTY_C);

   assign rd_data = mem[rd_ptr_q[dbit-1:0]];

   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign ovf_ev  = push & full;
   assign unf_ev  = pop & empty;

   always_comb begin
      wr_ptr_d    = wr_ptr_q + (dbit+1)'(push_ok);
      rd_ptr_d    = rd_ptr_q + (dbit+1)'(pop_ok);
      count_d     = count + (dbit+1)'(push_ok) - (dbit+1)'(pop_ok);
      peak_d      = peak_q;
      overflow_d  = overflow_q | ovf_ev;
      underflow_d = underflow_q | unf_ev;
      if (clr_err) begin
         // An error arriving with the clear is kept, not lost.
         overflow_d  = ovf_ev;
         underflow_d = unf_ev;
         peak_d      = count_d;
      end else if (count_d > peak_q) begin
         peak_d = count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         peak_q      <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         peak_q      <= peak_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is not reset; pushes during reset are dropped.
   always_ff @(posedge clk) begin
      if (push_ok && !reset) begin
         mem[wr_ptr_q[dbit-1:0]] <= wr_data;
      end
   end

   assign peak      = peak_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule

// File: tb/tb_shep_fifo_stat.sv
module tb_shep_fifo_stat;

   localparam int W  = 8;
   localparam int D  = 8;
   localparam int DB = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic [W-1:0]  wr_data;
   logic          push, pop, clr_err;
   logic [W-1:0]  rd_data;
   logic          empty, full, afull, aempty, overflow, underflow;
   logic [DB:0]   count, peak;

   int n_checks = 0;
   int n_fail   = 0;
   int mcount   = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] dv;

   always #5 clk = ~clk;

   shep_fifo_stat #(.width(W), .depth(D), .dbit(DB), .afull_lvl(2), .aempty_lvl(1)) dut (
      .clk(clk), .reset(reset), .wr_data(wr_data), .push(push), .rd_data(rd_data),
      .pop(pop), .clr_err(clr_err), .empty(empty), .full(full), .afull(afull),
      .aempty(aempty), .count(count), .peak(peak), .overflow(overflow),
      .underflow(underflow)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of requests, update the reference model, return #1 after the edge.
   task automatic step(input logic p, input logic po, input logic [W-1:0] d,
                       input logic clr, input logic rst);
      bit pa, pb;
      push = p; pop = po; wr_data = d; clr_err = clr; reset = rst;
      pa = p && (mcount < D) && !rst;
      pb = po && (mcount > 0) && !rst;
      if (rst) begin
         exp_q.delete();
         mcount = 0;
      end else begin
         if (pa) exp_q.push_back(d);
         mcount = mcount + int'(pa) - int'(pb);
      end
      @(posedge clk);
      #1;
      push = 0; pop = 0; clr_err = 0; reset = 0;
   endtask

   task automatic flags(input int c, input int pk, input int ov, input int un);
      chk("count", count, c);
      chk("peak", peak, pk);
      chk("overflow", overflow, ov);
      chk("underflow", underflow, un);
      chk("empty", empty, int'(c == 0));
      chk("full", full, int'(c == D));
      chk("afull", afull, int'(c >= D - 2));
      chk("aempty", aempty, int'(c <= 1));
   endtask

   // Scoreboard monitor: compares the head word whenever the DUT accepts a pop.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset && pop && !empty) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL rd_data: got %0h expected none (queue empty) at %0t", rd_data, $time);
            end else begin
               chk("rd_data", rd_data, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      reset = 1; push = 0; pop = 0; clr_err = 0; wr_data = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 0;
      flags(0, 0, 0, 0);

      // Fill and drain
      for (int i = 0; i < 8; i++) begin
         step(1, 0, W'(i), 0, 0);
         flags(i + 1, i + 1, 0, 0);
      end
      // Overflow: push while full with pop
      step(1, 1, 8'hAA, 0, 0);
      flags(7, 8, 1, 0);
      for (int i = 0; i < 7; i++) begin
         step(0, 1, 0, 0, 0);
         flags(6 - i, 8, 1, 0);
      end

      // Underflow: push and pop on empty
      step(1, 1, 8'h55, 0, 0);
      flags(1, 8, 1, 1);
      chk("rd_data_after_unf", rd_data, 8'h55);

      // Clear everything; peak reloads with occupancy
      step(0, 0, 0, 1, 0);
      flags(1, 1, 0, 0);

      // Wrap: hold count at 3 with simultaneous push/pop
      dv = 8'h10;
      step(1, 0, dv, 0, 0); dv++;
      step(1, 0, dv, 0, 0); dv++;
      flags(3, 3, 0, 0);
      for (int i = 0; i < 40; i++) begin
         step(1, 1, dv, 0, 0); dv++;
         chk("wrap_count", count, 3);
         chk("wrap_ovf", overflow, 0);
         chk("wrap_unf", underflow, 0);
      end
      chk("wrap_peak", peak, 3);

      // Clear-error race: fill, overflow, then clr_err with a new rejected push
      for (int i = 0; i < 5; i++) begin
         step(1, 0, dv, 0, 0); dv++;
      end
      flags(8, 8, 0, 0);
      step(1, 0, 8'hEE, 0, 0);
      flags(8, 8, 1, 0);
      step(1, 0, 8'hEF, 1, 0);
      flags(8, 8, 1, 0);
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      flags(6, 8, 1, 0);
      step(0, 0, 0, 1, 0);
      flags(6, 6, 0, 0);

      // Reset mid-stream at count 5 with a push
      step(0, 1, 0, 0, 0);
      flags(5, 6, 0, 0);
      step(1, 0, 8'h77, 0, 1);
      flags(0, 0, 0, 0);
      step(1, 0, 8'hC1, 0, 0);
      step(1, 0, 8'hC2, 0, 0);
      step(1, 0, 8'hC3, 0, 0);
      flags(3, 3, 0, 0);
      chk("head_after_reset", rd_data, 8'hC1);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
      flags(0, 3, 0, 0);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
